// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared state encodings and constants for the memory access controller
package mem_access_ctrl_pkg;
  localparam int MAC_ADDR_W = 26;
  localparam int MAC_DATA_W = 32;
  localparam int MAC_CNT_W = 8;
  localparam logic MAC_FILL_BIT = 1'b1;
  typedef enum logic [1:0] {
    MAC_IDLE   = 2'd0,
    MAC_ACCESS = 2'd1,
    MAC_DONE   = 2'd2
  } mac_state_t;
endpackage

// File: rtl/mac_wait_counter.sv
// mac_wait_counter: 8-bit access-cycle counter with minimum-wait and timeout compares
module mac_wait_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic min_met,
  output logic expired
);
  logic [MAC_CNT_W-1:0] cnt;
  // counts ACCESS cycles; the exit at TIMEOUT (<=255) keeps it from wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + MAC_CNT_W'(1);
  assign min_met = cnt >= MAC_CNT_W'(MIN_WAIT);
  assign expired = cnt == MAC_CNT_W'(TIMEOUT);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns READ/WRITE level strobes into a bounded memory access with a READY handshake
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MAC_ADDR_W,
  parameter int DATA_WIDTH = MAC_DATA_W,
  parameter int MIN_WAIT   = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  ERR,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  MEM_CS,
  output logic                  MEM_WE,
  input  logic                  MEM_ACK
);
  mac_state_t state, state_d;
  logic min_met, expired, ack_ok, finish;
  logic req_one, req_both, req_none;
  assign req_one  = READ ^ WRITE;
  assign req_both = READ & WRITE;
  assign req_none = ~(READ | WRITE);
  assign ack_ok   = MEM_ACK & min_met;
  assign finish   = ack_ok | expired;
  mac_wait_counter #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) u_wait (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (state == MAC_IDLE),
    .en     (state == MAC_ACCESS),
    .min_met(min_met),
    .expired(expired)
  );
  // next state: completion or timeout both leave ACCESS; release needs both strobes low
  always_comb begin
    state_d = state == MAC_IDLE   ? (req_one ? MAC_ACCESS : req_both ? MAC_DONE : MAC_IDLE) :
              state == MAC_ACCESS ? (finish ? MAC_DONE : MAC_ACCESS) :
              state == MAC_DONE   ? (req_none ? MAC_IDLE : MAC_DONE) : MAC_IDLE;
  end
  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= MAC_IDLE;
    else state <= state_d;
  // datapath; MEM_WE doubles as the latched op, so a read is MEM_WE=0 while in ACCESS
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      DATA_R    <= '0;
      READY     <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_CS    <= 1'b0;
      MEM_WE    <= 1'b0;
    end else begin
      if (state == MAC_IDLE && req_one) begin
        MEM_ADDR  <= ADDR;
        MEM_WDATA <= DATA_W;
        MEM_CS    <= 1'b1;
        MEM_WE    <= WRITE;
        BUSY      <= 1'b1;
      end
      if (state == MAC_IDLE && req_both) begin
        READY <= 1'b1;
        ERR   <= 1'b1;
      end
      if (state == MAC_ACCESS && finish) begin
        if (!MEM_WE) DATA_R <= ack_ok ? MEM_RDATA : {DATA_WIDTH{MAC_FILL_BIT}};
        READY  <= 1'b1;
        ERR    <= ~ack_ok;
        MEM_CS <= 1'b0;
        MEM_WE <= 1'b0;
        BUSY   <= 1'b0;
      end
      if (state == MAC_DONE && req_none) begin
        READY <= 1'b0;
        ERR   <= 1'b0;
      end
    end
endmodule
